dense_bias_sequencer: RTL

Sequences the final dense layer of the MNIST classifier. It accepts the 10 per-class dot-product accumulations from the dense MAC over a valid/ready handshake. It drives the address of the dense bias LUT and adds each bias to its accumulation. It streams the biased logits downstream and reports the argmax as the classified digit with a one-cycle done pulse.

---
 rtl/dense_bias_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dense_bias_sequencer.sv
// dense_bias_sequencer
// Final dense-layer sequencer of the MNIST classifier: accepts the per-class
// dot-product accumulations, adds the matching bias read from the dense bias
// LUT, streams the biased logits and reports the argmax class with a done pulse.
// Optional feature: define DENSE_BIAS_SAT_EN to make the bias add saturate
// instead of wrapping modulo 2^WORD_SIZE.

module dense_bias_sequencer #(
    parameter int WORD_SIZE   = 32,
    parameter int NUM_CLASSES = 10,
    parameter int ADR_SIZE    = $clog2(NUM_CLASSES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    input  logic                 acc_valid,
    output logic                 acc_ready,
    input  logic [WORD_SIZE-1:0] acc_data,
    output logic [ADR_SIZE-1:0]  lut_adr,
    input  logic [WORD_SIZE-1:0] lut_data,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] out_data,
    output logic [ADR_SIZE-1:0]  out_idx,
    output logic                 done,
    output logic [ADR_SIZE-1:0]  digit,
    output logic [WORD_SIZE-1:0] max_value
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [ADR_SIZE-1:0] LAST_IDX = ADR_SIZE'(NUM_CLASSES - 1);
    localparam logic [ADR_SIZE-1:0] ZERO_IDX = {ADR_SIZE{1'b0}};
    localparam logic [WORD_SIZE-1:0] ZERO_WORD = {WORD_SIZE{1'b0}};

    // Bias add: two's complement sum, clamped to the signed range when the
    // saturating build is selected, otherwise wrapping.
    function automatic logic [WORD_SIZE-1:0] bias_add(
        input logic [WORD_SIZE-1:0] a,
        input logic [WORD_SIZE-1:0] b
    );
        logic [WORD_SIZE-1:0] raw;
`ifdef DENSE_BIAS_SAT_EN
        logic ovf;
`endif
        raw = a + b;
`ifdef DENSE_BIAS_SAT_EN
        // Overflow only when both operands share a sign the result lacks.
        ovf = (a[WORD_SIZE-1] == b[WORD_SIZE-1]) && (raw[WORD_SIZE-1] != a[WORD_SIZE-1]);
        if (ovf) begin
            if (a[WORD_SIZE-1]) begin
                bias_add = {1'b1, {(WORD_SIZE-1){1'b0}}};
            end else begin
                bias_add = {1'b0, {(WORD_SIZE-1){1'b1}}};
            end
        end else begin
            bias_add = raw;
        end
`else
        bias_add = raw;
`endif
        return bias_add;
    endfunction

    state_e                state_q, state_d;
    logic [ADR_SIZE-1:0]   idx_q, idx_d;
    logic [WORD_SIZE-1:0]  max_q, max_d;
    logic [ADR_SIZE-1:0]   maxidx_q, maxidx_d;
    logic                  first_q, first_d;
    logic                  out_valid_q, out_valid_d;
    logic [WORD_SIZE-1:0]  out_data_q, out_data_d;
    logic [ADR_SIZE-1:0]   out_idx_q, out_idx_d;
    logic                  done_q, done_d;
    logic [ADR_SIZE-1:0]   digit_q, digit_d;
    logic [WORD_SIZE-1:0]  max_value_q, max_value_d;

    logic                  xfer_s;
    logic [WORD_SIZE-1:0]  sum_s;

    // Handshake and LUT address decode straight from the state register.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        acc_ready = (state_q == ST_RUN);
        if (state_q == ST_RUN) begin
            lut_adr = idx_q;
        end else begin
            lut_adr = ZERO_IDX;
        end
        xfer_s = acc_valid && (state_q == ST_RUN);
        sum_s  = bias_add(acc_data, lut_data);
    end

    // Next-state, running argmax and output-register computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        max_d       = max_q;
        maxidx_d    = maxidx_q;
        first_d     = first_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        done_d      = 1'b0;
        digit_d     = digit_q;
        max_value_d = max_value_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d    = ZERO_IDX;
                    max_d    = ZERO_WORD;
                    maxidx_d = ZERO_IDX;
                    first_d  = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    idx_d = ZERO_IDX;
                end
            end
            ST_RUN: begin
                if (xfer_s) begin
                    out_data_d  = sum_s;
                    out_idx_d   = idx_q;
                    out_valid_d = 1'b1;
                    // Strict compare keeps the lowest index on ties.
                    if (first_q || ($signed(sum_s) > $signed(max_q))) begin
                        max_d    = sum_s;
                        maxidx_d = idx_q;
                    end else begin
                        max_d    = max_q;
                        maxidx_d = maxidx_q;
                    end
                    first_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + ADR_SIZE'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                digit_d     = maxidx_q;
                max_value_d = max_q;
                done_d      = 1'b1;
                idx_d       = ZERO_IDX;
                state_d     = ST_IDLE;
            end
            default: begin
                idx_d   = ZERO_IDX;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= ZERO_IDX;
            max_q       <= ZERO_WORD;
            maxidx_q    <= ZERO_IDX;
            first_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= ZERO_WORD;
            out_idx_q   <= ZERO_IDX;
            done_q      <= 1'b0;
            digit_q     <= ZERO_IDX;
            max_value_q <= ZERO_WORD;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            max_q       <= max_d;
            maxidx_q    <= maxidx_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            done_q      <= done_d;
            digit_q     <= digit_d;
            max_value_q <= max_value_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign done      = done_q;
    assign digit     = digit_q;
    assign max_value = max_value_q;

endmodule
